// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPoll,
    StCheck,
    StWrite,
    StPfxId,
    StPfxColon
  } arb_state_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Memory-mapped UART port: master drives strobes/address/data, slave returns registered read data.
interface uart_tx_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    readEnable;
  logic                    writeEnable;
  logic [DATA_WIDTH/8-1:0] writeByteEnable;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   writeData;
  logic [DATA_WIDTH-1:0]   readData;

  modport master (
    output readEnable,
    output writeEnable,
    output writeByteEnable,
    output address,
    output writeData,
    input  readData
  );

  modport slave (
    input  readEnable,
    input  writeEnable,
    input  writeByteEnable,
    input  address,
    input  writeData,
    output readData
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             found;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((32'(pointer) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, line-locking arbiter sharing a polled UART TX register among NUM_REQ byte streams.
// Optional per-line "<id>:" prefix when UART_ARB_PREFIX_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] TX_ADDR = ADDR_WIDTH'(32'h9000_0020),
  parameter logic [ADDR_WIDTH-1:0] TX_READY_ADDR = ADDR_WIDTH'(32'h9000_0024),
  parameter int unsigned LOCK_TIMEOUT = 1024,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  uart_tx_arbiter_if.master      bus,
  output logic [IDX_W-1:0]       grant_id,
  output logic                   locked
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [BE_W-1:0] BE_BYTE0 = BE_W'(1);

  arb_state_e       state_q;
  logic [IDX_W-1:0] pointer_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic [IDX_W-1:0] rr_grant;
  logic             rr_any;
  logic [7:0]       sel_byte;
  logic             unused_read_data;

`ifdef UART_ARB_PREFIX_EN
  typedef enum logic [1:0] {PfxNone, PfxColonNext, PfxIdNext} pfx_e;
  pfx_e pfx_q;
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req    (req_valid),
    .pointer(pointer_q),
    .grant  (rr_grant),
    .any_req(rr_any)
  );

  assign sel_byte = req_data[{grant_id, 3'b000} +: 8];
  assign unused_read_data = ^bus.readData[DATA_WIDTH-1:1];

  // Strobes are registered and default low; each state sets what the next cycle drives.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q             <= StIdle;
      pointer_q           <= IDX_W'(NUM_REQ - 1);
      lock_cnt_q          <= '0;
      grant_id            <= '0;
      locked              <= 1'b0;
      req_ready           <= '0;
      bus.readEnable      <= 1'b0;
      bus.writeEnable     <= 1'b0;
      bus.writeByteEnable <= '0;
      bus.address         <= '0;
      bus.writeData       <= '0;
`ifdef UART_ARB_PREFIX_EN
      pfx_q               <= PfxNone;
`endif
    end else begin
      req_ready           <= '0;
      bus.readEnable      <= 1'b0;
      bus.writeEnable     <= 1'b0;
      bus.writeByteEnable <= '0;
      bus.address         <= '0;
      bus.writeData       <= '0;
      case (state_q)
        StIdle: begin
          if (locked) begin
            if (req_valid[grant_id]) begin
              state_q        <= StPoll;
              bus.readEnable <= 1'b1;
              bus.address    <= TX_READY_ADDR;
            end else if (lock_cnt_q == CNT_LAST) begin
              locked     <= 1'b0;
              lock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_q + CNT_W'(1);
            end
          end else if (rr_any) begin
            grant_id       <= rr_grant;
            pointer_q      <= rr_grant;
            state_q        <= StPoll;
            bus.readEnable <= 1'b1;
            bus.address    <= TX_READY_ADDR;
`ifdef UART_ARB_PREFIX_EN
            pfx_q          <= PfxIdNext;
`endif
          end
        end
        StPoll: state_q <= StCheck;
        StCheck: begin
          if (bus.readData[0]) begin
            bus.writeEnable     <= 1'b1;
            bus.address         <= TX_ADDR;
            bus.writeByteEnable <= BE_BYTE0;
`ifdef UART_ARB_PREFIX_EN
            if (pfx_q == PfxIdNext) begin
              state_q       <= StPfxId;
              bus.writeData <= DATA_WIDTH'(ASCII_ZERO + 8'(grant_id));
            end else if (pfx_q == PfxColonNext) begin
              state_q       <= StPfxColon;
              bus.writeData <= DATA_WIDTH'(ASCII_COLON);
            end else begin
              state_q             <= StWrite;
              bus.writeData       <= DATA_WIDTH'(sel_byte);
              req_ready[grant_id] <= 1'b1;
            end
`else
            state_q             <= StWrite;
            bus.writeData       <= DATA_WIDTH'(sel_byte);
            req_ready[grant_id] <= 1'b1;
`endif
          end else begin
            state_q        <= StPoll;
            bus.readEnable <= 1'b1;
            bus.address    <= TX_READY_ADDR;
          end
        end
        StWrite: begin
          state_q    <= StIdle;
          locked     <= (bus.writeData[7:0] != ASCII_LF);
          lock_cnt_q <= '0;
        end
`ifdef UART_ARB_PREFIX_EN
        StPfxId: begin
          pfx_q          <= PfxColonNext;
          state_q        <= StPoll;
          bus.readEnable <= 1'b1;
          bus.address    <= TX_READY_ADDR;
        end
        StPfxColon: begin
          pfx_q          <= PfxNone;
          state_q        <= StPoll;
          bus.readEnable <= 1'b1;
          bus.address    <= TX_READY_ADDR;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, self-checking bench for uart_tx_arbiter; UART_ARB_PREFIX_EN selects the prefix scenario.
module tb_uart_tx_arbiter;
  localparam int unsigned N = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           locked;

  uart_tx_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .LOCK_TIMEOUT(16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .bus      (bus),
    .grant_id (grant_id),
    .locked   (locked)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [3:0]  wbe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rdy;
    logic        lk;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int busy_polls = 0;
  int re_cnt = 0;
  int rdy_cnt = 0;
  int rdy_bad = 0;
  logic [7:0] strm [N][8];
  int len [N];
  int pos [N];
  vec_t s;
  logic [1:0] s_gnt;
  logic [7:0] wr_byte [$];
  logic [1:0] wr_gnt [$];
  logic       wr_lock [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pos[i] < len[i]);
      req_data[8*i +: 8] = (pos[i] < len[i]) ? strm[i][pos[i]] : 8'h00;
    end
  endtask

  task automatic load(input int i, input string str);
    len[i] = str.len();
    pos[i] = 0;
    for (int k = 0; k < str.len() && k < 8; k++) strm[i][k] = str[k];
  endtask

  // One clock: sample outputs at the falling edge, then play the UART and requester models.
  task automatic step();
    @(negedge clock);
    s = '{bus.readEnable, bus.writeEnable, bus.writeByteEnable, bus.address, bus.writeData,
          req_ready, locked};
    s_gnt = grant_id;
    checks++;
    if ((s.re && s.we) || !$onehot0(s.rdy) || (!s.we && s.wdata != 32'h0)) begin
      errors++;
      $display("FAIL strobe_rules: re=%b we=%b rdy=%b wdata=%h required exclusive/onehot0/zero",
               s.re, s.we, s.rdy, s.wdata);
    end
    if (s.re) begin
      re_cnt++;
      bus.readData = (busy_polls > 0) ? 32'd0 : 32'd1;
      if (busy_polls > 0) busy_polls--;
    end
    if (s.we) begin
      wr_byte.push_back(s.wdata[7:0]);
      wr_gnt.push_back(s_gnt);
      wr_lock.push_back(s.lk);
    end
    if (s.rdy != 4'h0 && !s.we) rdy_bad++;
    for (int i = 0; i < N; i++) begin
      if (s.rdy[i]) begin
        rdy_cnt++;
        pos[i]++;
      end
    end
    drive_reqs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    drive_reqs();
    busy_polls = 0;
    bus.readData = 32'h0;
    step();
    step();
    reset = 1'b0;
    wr_byte.delete();
    wr_gnt.delete();
    wr_lock.delete();
    re_cnt = 0;
    rdy_cnt = 0;
    rdy_bad = 0;
  endtask

  task automatic run_until_writes(input int n, input int bound);
    int k;
    k = 0;
    while (wr_byte.size() < n && k < bound) begin
      step();
      k++;
    end
    chk("write_count", 32'(wr_byte.size()), 32'(n));
  endtask

  initial begin
    vec_t tv [5];
    logic [7:0] exp_bytes [6];
    logic [1:0] exp_gnt [6];
    logic       exp_lock [6];
    int first_re;

    do_reset();
    chk("reset_re", 32'(s.re), 32'd0);
    chk("reset_we", 32'(s.we), 32'd0);
    chk("reset_wbe", 32'(s.wbe), 32'd0);
    chk("reset_addr", s.addr, 32'd0);
    chk("reset_wdata", s.wdata, 32'd0);
    chk("reset_rdy", 32'(s.rdy), 32'd0);
    chk("reset_gnt", 32'(s_gnt), 32'd0);
    chk("reset_lock", 32'(s.lk), 32'd0);

`ifdef UART_ARB_PREFIX_EN
    load(2, "x\n");
    drive_reqs();
    run_until_writes(4, 60);
    exp_bytes[0] = 8'h32; exp_bytes[1] = 8'h3A; exp_bytes[2] = 8'h78; exp_bytes[3] = 8'h0A;
    for (int k = 0; k < 4 && k < wr_byte.size(); k++)
      chk($sformatf("prefix_byte[%0d]", k), 32'(wr_byte[k]), 32'(exp_bytes[k]));
    chk("prefix_ready_pulses", 32'(rdy_cnt), 32'd2);
`else
    // Single byte, per-cycle expectations from the first POLL onward.
    tv[0] = '{1'b1, 1'b0, 4'h0, 32'h9000_0024, 32'h0, 4'h0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 4'h1, 32'h9000_0020, 32'h41, 4'h1, 1'b0};
    tv[3] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b1};
    tv[4] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b1};
    load(0, "A");
    drive_reqs();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (s !== tv[k]) begin
        errors++;
        $display("FAIL single_byte[%0d]: got %h expected %h", k, s, tv[k]);
      end
    end

    // Backpressure: five "full" polls before space appears.
    do_reset();
    busy_polls = 5;
    load(0, "Z");
    drive_reqs();
    run_until_writes(1, 80);
    chk("bp_polls", 32'(re_cnt), 32'd6);
    chk("bp_early_ready", 32'(rdy_bad), 32'd0);
    chk("bp_ready_pulses", 32'(rdy_cnt), 32'd1);
    if (wr_byte.size() > 0) chk("bp_byte", 32'(wr_byte[0]), 32'h5A);

    // No interleave between two simultaneous lines.
    do_reset();
    load(0, "hi\n");
    load(1, "ok\n");
    drive_reqs();
    run_until_writes(6, 120);
    exp_bytes = '{8'h68, 8'h69, 8'h0A, 8'h6F, 8'h6B, 8'h0A};
    exp_gnt   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    exp_lock  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6 && k < wr_byte.size(); k++) begin
      chk($sformatf("line_byte[%0d]", k), 32'(wr_byte[k]), 32'(exp_bytes[k]));
      chk($sformatf("line_gnt[%0d]", k), 32'(wr_gnt[k]), 32'(exp_gnt[k]));
      chk($sformatf("line_lock[%0d]", k), 32'(wr_lock[k]), 32'(exp_lock[k]));
    end

    // Fairness with every requester sending bare newlines.
    do_reset();
    for (int i = 0; i < N; i++) load(i, "\n\n\n");
    drive_reqs();
    run_until_writes(6, 120);
    exp_gnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 6 && k < wr_gnt.size(); k++)
      chk($sformatf("fair_gnt[%0d]", k), 32'(wr_gnt[k]), 32'(exp_gnt[k]));

    // Lock timeout: req0 leaves a line open, req1 waits out 16 idle cycles.
    do_reset();
    load(0, "ab");
    load(1, "q");
    drive_reqs();
    run_until_writes(2, 60);
    first_re = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 16) begin
        chk("timeout_lock_held", 32'(s.lk), 32'd1);
        chk("timeout_gnt_held", 32'(s_gnt), 32'd0);
      end
      if (k == 17) chk("timeout_lock_clear", 32'(s.lk), 32'd0);
      if (s.re) begin
        first_re = k;
        chk("timeout_new_gnt", 32'(s_gnt), 32'd1);
        break;
      end
    end
    chk("timeout_first_poll", 32'(first_re), 32'd18);

    // Reset while in CHECK aborts the write; byte is resent afterwards.
    do_reset();
    load(0, "R");
    drive_reqs();
    step();
    chk("midrst_poll", 32'(s.re), 32'd1);
    step();
    reset = 1'b1;
    step();
    chk("midrst_outputs", {s.re, s.we, s.wbe, s.rdy, s_gnt, s.lk}, 32'd0);
    chk("midrst_addr_data", s.addr | s.wdata, 32'd0);
    chk("midrst_no_write", 32'(wr_byte.size()), 32'd0);
    reset = 1'b0;
    run_until_writes(1, 40);
    if (wr_byte.size() > 0) chk("midrst_byte", 32'(wr_byte[0]), 32'h52);
    chk("midrst_ready_pulses", 32'(rdy_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
